// File: rtl/defs.sv
// Shared definitions for the load/store unit: data width, access-size and
// FSM state enums, and a helper giving the byte span of an access.
package defs;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        LSU_B = 2'b00,
        LSU_H = 2'b01,
        LSU_W = 2'b10
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

    // Offset of the last byte touched by an access of the given size.
    function automatic logic [2:0] size_span(input logic [1:0] size);
        case (size)
            2'b00:   size_span = 3'd0;
            2'b01:   size_span = 3'd1;
            default: size_span = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational data lane: extends loaded bytes/halves to XLEN and merges a
// sub-word store into a previously read word.
module lsu_lane
    import defs::*;
(
    input  lsu_size_e        size,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  rd_word,
    input  logic [XLEN-1:0]  old_word,
    input  logic [XLEN-1:0]  st_data,
    output logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  merged_word
);

    logic [XLEN/8-1:0] byte_en;

    // Per-byte select: store data replaces only the bytes covered by the size.
    for (genvar gi = 0; gi < XLEN/8; gi++) begin : g_merge
        assign byte_en[gi] = (size == LSU_W) || (size == LSU_H && gi < 2) || (gi == 0);
        assign merged_word[8*gi +: 8] = byte_en[gi] ? st_data[8*gi +: 8] : old_word[8*gi +: 8];
    end

    // Load extension: pick the low 8/16/32 bits and sign- or zero-extend.
    always_comb begin
        load_data = rd_word;
        case (size)
            LSU_B:   load_data = {{(XLEN-8){~is_unsigned & rd_word[7]}}, rd_word[7:0]};
            LSU_H:   load_data = {{(XLEN-16){~is_unsigned & rd_word[15]}}, rd_word[15:0]};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-request FSM between the pipeline and a byte-addressed
// memory with combinational read. Sub-word stores are done read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module lsu
    import defs::*;
#(
    parameter int MEM_SIZE = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_err,
    output logic             mem_ren,
    output logic             mem_wen,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata
);

    lsu_state_e      state_reg, state_next, route_state;
    logic [XLEN-1:0] addr_reg, wdata_reg, word_reg, rsp_rdata_reg;
    lsu_size_e       size_reg;
    logic            unsigned_reg, rsp_valid_reg, rsp_err_reg;
    logic            accept, req_err, misalign;
    logic [XLEN:0]   last_byte;
    logic [XLEN-1:0] load_data, merged_word;

    assign req_ready = !rst && (state_reg == IDLE || state_reg == RESP);
    assign accept    = req_valid && req_ready;

    // Request legality and routing; the span check is one bit wider so it cannot wrap.
    always_comb begin
        last_byte = {1'b0, req_addr} + {{(XLEN-2){1'b0}}, size_span(req_size)};
`ifdef LSU_ALIGN_CHECK_EN
        misalign = (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        req_err = (req_size == 2'b11) || (last_byte >= (XLEN+1)'(MEM_SIZE)) || misalign;
        if (req_err)
            route_state = RESP;
        else if (!req_we)
            route_state = LOAD;
        else if (req_size == 2'b10)
            route_state = STORE;
        else
            route_state = RMW_RD;
    end

    // Next-state logic; acceptance in RESP chains straight into the next access.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = route_state;
            LOAD:    state_next = RESP;
            STORE:   state_next = RESP;
            RMW_RD:  state_next = RMW_WR;
            RMW_WR:  state_next = RESP;
            RESP:    state_next = accept ? route_state : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs; strobes are forced low during reset so an aborted RMW never writes.
    always_comb begin
        mem_ren   = !rst && (state_reg == LOAD || state_reg == RMW_RD);
        mem_wen   = !rst && (state_reg == STORE || state_reg == RMW_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == LOAD || state_reg == STORE || state_reg == RMW_RD || state_reg == RMW_WR)
            mem_addr = addr_reg;
        if (state_reg == STORE)
            mem_wdata = wdata_reg;
        else if (state_reg == RMW_WR)
            mem_wdata = merged_word;
    end

    lsu_lane u_lane (
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .rd_word     (mem_rdata),
        .old_word    (word_reg),
        .st_data     (wdata_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State, request capture, read-word capture and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            size_reg      <= LSU_B;
            unsigned_reg  <= 1'b0;
            word_reg      <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                size_reg     <= lsu_size_e'(req_size);
                unsigned_reg <= req_unsigned;
            end
            if (state_reg == LOAD || state_reg == RMW_RD)
                word_reg <= mem_rdata;
            rsp_valid_reg <= (state_next == RESP);
            rsp_err_reg   <= accept && req_err;
            rsp_rdata_reg <= (state_reg == LOAD) ? load_data : '0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array memory model attached to the DUT,
// independent reference memory for expected results, directed and random traffic.
module tb_lsu;

    localparam int MSZ = 4096;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem     [MSZ];
    logic [7:0]  ref_mem [MSZ];

    int checks   = 0;
    int failures = 0;

    lsu #(.MEM_SIZE(MSZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT: combinational little-endian read, word write on posedge.
    always_comb begin
        mem_rdata = '0;
        if (mem_ren)
            for (int i = 0; i < 4; i++)
                if (mem_addr + 32'(i) < 32'(MSZ))
                    mem_rdata[8*i +: 8] = mem[12'(mem_addr + 32'(i))];
    end

    always @(posedge clk) begin
        if (mem_wen)
            for (int i = 0; i < 4; i++)
                if (mem_addr + 32'(i) < 32'(MSZ))
                    mem[12'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if (a + i < MSZ) v[8*i +: 8] = ref_mem[a + i];
        return v;
    endfunction

    task automatic preset(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[a + i]     = w[8*i +: 8];
            ref_mem[a + i] = w[8*i +: 8];
        end
    endtask

    // One transaction, called #1 after a posedge. Expected values come from the
    // reference memory and the access rules, not from the DUT.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit expect_b2b, output logic [31:0] got_rd);
        int          n, exp_lat, exp_ren, exp_wen, n_ren, n_wen, lat, waited;
        logic        exp_err;
        logic [31:0] exp_rd;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_err = (sz == 2'd3) || (longint'(addr) + n - 1 >= MSZ);
`ifdef LSU_ALIGN_CHECK_EN
        if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)) exp_err = 1'b1;
`endif
        exp_rd = '0;
        if (exp_err) begin
            exp_lat = 1; exp_ren = 0; exp_wen = 0;
        end else if (!we) begin
            exp_lat = 2; exp_ren = 1; exp_wen = 0;
            for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
            if (!uns && n < 4 && exp_rd[8*n-1])
                for (int b = 8*n; b < 32; b++) exp_rd[b] = 1'b1;
        end else begin
            exp_lat = (n == 4) ? 2 : 3; exp_ren = (n == 4) ? 0 : 1; exp_wen = 1;
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        if (waited >= 20) chk("ready_timeout", 32'(waited), 32'd0);
        if (expect_b2b) chk("b2b_ready_wait", 32'(waited), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; n_ren = 0; n_wen = 0;
        while (!rsp_valid && lat < 8) begin
            if (mem_ren) n_ren++;
            if (mem_wen) n_wen++;
            if (mem_ren && mem_wen) chk("ren_wen_overlap", 32'd1, 32'd0);
            if (mem_ren || mem_wen) chk("mem_addr", mem_addr, addr);
            @(posedge clk); #1; lat++;
        end
        got_rd = rsp_rdata;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("ren_cycles", 32'(n_ren), 32'(exp_ren));
        chk("wen_cycles", 32'(n_wen), 32'(exp_wen));
        $display("txn we=%0d sz=%0d uns=%0d addr=%h wd=%h rd=%h err=%0d lat=%0d",
                 we, sz, uns, addr, wd, rsp_rdata, rsp_err, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [31:0] a;
        int          diffs, gap, r;

        for (int i = 0; i < MSZ; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_strobes", {30'd0, mem_ren, mem_wen}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        #1 chk("idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Byte loads, signed and unsigned.
        preset(32'h10, 32'h8899AABB);
        txn(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, rd);
        chk("lb_signed", rd, 32'hFFFFFFBB);
        txn(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b1, rd);
        chk("lb_unsigned", rd, 32'h000000BB);

        // Half store via read-modify-write.
        preset(32'h20, 32'h11223344);
        txn(1'b1, 2'd1, 1'b0, 32'h20, 32'hCAFEBEEF, 1'b0, rd);
        txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, rd);
        chk("sh_merge", rd, 32'h1122BEEF);

        // Back-to-back: load, word store in its RESP, load back.
        txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, rd);
        txn(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1, rd);
        txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, rd);
        chk("sw_readback", rd, 32'hDEADBEEF);

        // Errors: illegal size, span past the end of memory, misaligned word.
        txn(1'b1, 2'd3, 1'b0, 32'h80, 32'h12345678, 1'b0, rd);
        txn(1'b0, 2'd2, 1'b0, 32'hFFE, 32'h0, 1'b0, rd);
        txn(1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0, 1'b0, rd);
        txn(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1'b0, rd);

        // Reset during the RMW write cycle: no write, back to idle.
        @(posedge clk); #1;
        preset(32'h60, 32'h55667788);
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h60; req_wdata = 32'h000000AA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_rd_ren", 32'(mem_ren), 32'd1);
        @(posedge clk); #1;
        chk("rmw_wr_wen", 32'(mem_wen), 32'd1);
        rst = 1'b1;
        #1 chk("rst_gates_wen", 32'(mem_wen), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_outs", {29'd0, rsp_valid, mem_ren, mem_wen} | mem_addr | mem_wdata | rsp_rdata, 32'd0);
        chk("midrst_mem", {mem[32'h63], mem[32'h62], mem[32'h61], mem[32'h60]}, ref_word(32'h60));

        // A request presented while reset is high is ignored.
        req_we = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        #1 chk("rst_req_ignored_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_req_ignored_rsp", {30'd0, rsp_valid, mem_wen}, 32'd0);
        chk("rst_req_ignored_mem", {mem[32'h83], mem[32'h82], mem[32'h81], mem[32'h80]}, ref_word(32'h80));

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, MSZ - 1));
            else if (r < 9) a = 32'($urandom_range(MSZ - 8, MSZ - 1));
            else            a = $urandom;
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, rd);
        end

        @(posedge clk); #1;
        diffs = 0;
        for (int i = 0; i < MSZ; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_final_diffs", 32'(diffs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
